// File: rtl/ascon_patch_queue.sv
// ascon_patch_queue
// Builds a {source, destination} patch word for every control transfer reported by
// the ASCON control-flow FSM and queues it for the permutation datapath.
//
// Ports:
//   clk_core_slow_i               slow core clock, all state on the rising edge
//   rst_ni                        synchronous active-low reset
//   apply_patch_i, sel_patch_i    patch request and source (0=NULL, 1=IF, 2=ID, 3=EX)
//   sel_addr_redirected_i         capture strobe for addr_redirected_i
//   sel_previous_instr_addr_en_i  use held previous-instruction / redirected addresses
//   id_valid_i                    instruction leaves ID; pc_id_i is held as previous
//   pc_if_i, pc_id_i, pc_ex_i     pipeline stage PCs
//   addr_redirected_i             redirected jump target
//   patch_valid_o/patch_ready_i   head-of-queue handshake
//   patch_data_o, patch_src_o     head word {src, dest} and its sel_patch value
//   count_o                       occupancy 0..DEPTH
//   overflow_o                    sticky: a request was dropped on a full queue
module ascon_patch_queue #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                      clk_core_slow_i,
    input  logic                      rst_ni,
    input  logic                      apply_patch_i,
    input  logic [1:0]                sel_patch_i,
    input  logic                      sel_addr_redirected_i,
    input  logic                      sel_previous_instr_addr_en_i,
    input  logic                      id_valid_i,
    input  logic [ADDR_W-1:0]         pc_if_i,
    input  logic [ADDR_W-1:0]         pc_id_i,
    input  logic [ADDR_W-1:0]         pc_ex_i,
    input  logic [ADDR_W-1:0]         addr_redirected_i,
    output logic                      patch_valid_o,
    input  logic                      patch_ready_i,
    output logic [2*ADDR_W-1:0]       patch_data_o,
    output logic [1:0]                patch_src_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] PATCH_NULL = 2'd0;
    localparam logic [1:0] PATCH_IF   = 2'd1;
    localparam logic [1:0] PATCH_ID   = 2'd2;
    localparam logic [1:0] PATCH_EX   = 2'd3;

    logic [ADDR_W-1:0]   r_prev_addr;
    logic [ADDR_W-1:0]   r_redir_addr;
    logic [2*ADDR_W-1:0] r_mem [DEPTH];
    logic [1:0]          r_src_mem [DEPTH];
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_redir;
    logic [ADDR_W-1:0]   w_src;
    logic [ADDR_W-1:0]   w_dest;

    // Same-cycle capture strobe bypasses the held redirected target.
    assign w_redir = sel_addr_redirected_i ? addr_redirected_i : r_redir_addr;
    assign w_src   = sel_previous_instr_addr_en_i ? r_prev_addr : pc_id_i;

    always_comb begin
        w_dest = pc_id_i;
        case (sel_patch_i)
            PATCH_IF: w_dest = sel_previous_instr_addr_en_i ? w_redir : pc_if_i;
            PATCH_ID: w_dest = pc_id_i;
            PATCH_EX: w_dest = pc_ex_i;
            default:  w_dest = pc_id_i;
        endcase
    end

    assign w_push  = apply_patch_i && (sel_patch_i != PATCH_NULL);
    assign w_pop   = (r_count != '0) && patch_ready_i;
    assign w_full  = (r_count == CNT_W'(DEPTH));
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge clk_core_slow_i) begin
        if (!rst_ni) begin
            r_prev_addr  <= '0;
            r_redir_addr <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (id_valid_i)            r_prev_addr  <= pc_id_i;
            if (sel_addr_redirected_i) r_redir_addr <= addr_redirected_i;
            if (w_wr_en)               r_wr_ptr     <= r_wr_ptr + PTR_W'(1);
            if (w_pop)                 r_rd_ptr     <= r_rd_ptr + PTR_W'(1);
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are masked whenever the queue is empty.
    always_ff @(posedge clk_core_slow_i) begin
        if (rst_ni && w_wr_en) begin
            r_mem[r_wr_ptr]     <= {w_src, w_dest};
            r_src_mem[r_wr_ptr] <= sel_patch_i;
        end
    end

    assign patch_valid_o = (r_count != '0);
    assign patch_data_o  = patch_valid_o ? r_mem[r_rd_ptr] : '0;
    assign patch_src_o   = patch_valid_o ? r_src_mem[r_rd_ptr] : 2'd0;
    assign count_o       = r_count;
    assign overflow_o    = r_overflow;

endmodule
